iter_alu: RTL



---
 rtl/alu_pkg.sv | 23 ++
 rtl/iter_muldiv.sv | 69 ++++++
 rtl/iter_alu.sv | 138 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants and FSM state type shared by the iterative ALU
package alu_pkg;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_NAND  = 4'b0010;
   localparam logic [3:0] OP_NOR   = 4'b0011;
   localparam logic [3:0] OP_XOR   = 4'b0100;
   localparam logic [3:0] OP_XNOR  = 4'b0101;
   localparam logic [3:0] OP_NOT   = 4'b0110;
   localparam logic [3:0] OP_ADD   = 4'b0111;
   localparam logic [3:0] OP_SUB   = 4'b1000;
   localparam logic [3:0] OP_MUL   = 4'b1001;
   localparam logic [3:0] OP_DIV   = 4'b1010;
   localparam logic [3:0] OP_SHIFT = 4'b1011;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } alu_state_t;

endpackage

// File: rtl/iter_muldiv.sv
// rtl/iter_muldiv.sv - one-bit-per-cycle shift-add multiplier and restoring divider
module iter_muldiv #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [CW-1:0]    cnt;
   logic             is_div;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_sh;
   logic [WIDTH:0]   div_diff;

   // acc is the product high half for MUL and the partial remainder for DIV;
   // q holds the multiplier / product low half, or the dividend / quotient.
   always_comb begin
      mul_sum  = {1'b0, acc} + (q[0] ? {1'b0, dvs} : '0);
      div_sh   = {acc, q[WIDTH-1]};
      div_diff = div_sh - {1'b0, dvs};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         is_div <= 1'b0;
         acc    <= '0;
         q      <= '0;
         dvs    <= '0;
      end else if (start) begin
         cnt    <= CW'(WIDTH);
         is_div <= op_div;
         acc    <= '0;
         q      <= a;
         dvs    <= b;
      end else if (cnt != '0) begin
         cnt <= cnt - CW'(1);
         if (is_div) begin
            if (!div_diff[WIDTH]) begin
               acc <= div_diff[WIDTH-1:0];
               q   <= {q[WIDTH-2:0], 1'b1};
            end else begin
               acc <= div_sh[WIDTH-1:0];
               q   <= {q[WIDTH-2:0], 1'b0};
            end
         end else begin
            acc <= mul_sum[WIDTH:1];
            q   <= {mul_sum[0], q[WIDTH-1:1]};
         end
      end
   end

   assign done   = (cnt == CW'(1));
   assign res_hi = is_div ? q : acc;
   assign res_lo = is_div ? acc : q;

endmodule

// File: rtl/iter_alu.sv
// rtl/iter_alu.sv - handshaked ALU: single-cycle logic/add/sub/shift, iterative mul/div
module iter_alu import alu_pkg::*; #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carryin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] extra,
   output logic             err
);

   alu_state_t         state, state_nxt;
   logic               accept;
   logic               is_iter;
   logic               md_done;
   logic [WIDTH-1:0]   md_hi, md_lo;
   logic [WIDTH-1:0]   sc_out, sc_extra;
   logic               sc_err;
   logic [WIDTH-1:0]   out_q, extra_q;
   logic               err_q, iter_q;
   logic [WIDTH:0]     add_sum, sub_diff;
   logic [2*WIDTH-1:0] sh_t, sh_mask;
   int                 amt;

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign accept    = in_valid && in_ready;
   assign is_iter   = (opcode == OP_MUL) || ((opcode == OP_DIV) && (b != '0));

   always_comb begin
      add_sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carryin};
      sub_diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, carryin};
      amt = int'(b[WIDTH-2:1]);
      if (amt > WIDTH) amt = WIDTH;
      // Shifted-in positions are zero, so OR-ing the fill mask places the fill bits.
      if (b[WIDTH-1]) begin
         sh_mask = ~({2*WIDTH{1'b1}} << amt);
         sh_t    = ({{WIDTH{1'b0}}, a} << amt) | (b[0] ? sh_mask : '0);
      end else begin
         sh_mask = ~({2*WIDTH{1'b1}} >> amt);
         sh_t    = ({a, {WIDTH{1'b0}}} >> amt) | (b[0] ? sh_mask : '0);
      end

      sc_out   = '0;
      sc_extra = '0;
      sc_err   = 1'b0;
      case (opcode)
         OP_AND:  sc_out = a & b;
         OP_OR:   sc_out = a | b;
         OP_NAND: sc_out = ~(a & b);
         OP_NOR:  sc_out = ~(a | b);
         OP_XOR:  sc_out = a ^ b;
         OP_XNOR: sc_out = ~(a ^ b);
         OP_NOT:  sc_out = ~a;
         OP_ADD: begin
            sc_out   = add_sum[WIDTH-1:0];
            sc_extra = {{(WIDTH-1){1'b0}}, add_sum[WIDTH]};
         end
         OP_SUB: begin
            sc_out   = sub_diff[WIDTH-1:0];
            sc_extra = {{(WIDTH-1){1'b0}}, ~sub_diff[WIDTH]};
         end
         OP_MUL: sc_out = '0;
         OP_DIV: begin
            if (b == '0) begin
               sc_out   = '1;
               sc_extra = a;
               sc_err   = 1'b1;
            end
         end
         OP_SHIFT: begin
            if (b[WIDTH-1]) begin
               sc_out   = sh_t[WIDTH-1:0];
               sc_extra = sh_t[2*WIDTH-1:WIDTH];
            end else begin
               sc_out   = sh_t[2*WIDTH-1:WIDTH];
               sc_extra = sh_t[WIDTH-1:0];
            end
         end
         default: sc_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept) state_nxt = is_iter ? ST_BUSY : ST_DONE;
         ST_BUSY: if (md_done) state_nxt = ST_DONE;
         ST_DONE: if (out_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q   <= '0;
         extra_q <= '0;
         err_q   <= 1'b0;
         iter_q  <= 1'b0;
      end else if (accept) begin
         out_q   <= sc_out;
         extra_q <= sc_extra;
         err_q   <= sc_err;
         iter_q  <= is_iter;
      end
   end

   // Iterative results are read straight from the engine, which freezes once its count expires.
   assign out   = iter_q ? md_hi : out_q;
   assign extra = iter_q ? md_lo : extra_q;
   assign err   = err_q;

   iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (accept && is_iter),
      .op_div (opcode == OP_DIV),
      .a      (a),
      .b      (b),
      .done   (md_done),
      .res_hi (md_hi),
      .res_lo (md_lo)
   );

endmodule
